// File: rtl/pixel_window_3x3.sv
// pixel_window_3x3: builds a 3x3 neighbourhood window from a raster-order
// pixel stream using two line buffers, and flags windows lying fully
// inside the image.
//
// Ports:
//   clk, rst_n    - clock (posedge), asynchronous active-low reset
//   frame_start   - synchronous clear of the row/column position
//   in_valid      - pixel qualifier; in_data ignored when low
//   in_data       - pixel value
//   win_valid     - win_data holds a complete in-image window (1-cycle pulse)
//   win_data      - window bus, p[r][c] at [DATA_W*(3*r+c) +: DATA_W],
//                   r=0 oldest row, c=0 leftmost column
//   frame_done    - only with PIXEL_WINDOW_FRAME_DONE_EN defined: pulses
//                   with the window of the last pixel of the frame
module pixel_window_3x3 #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                win_valid,
   output logic [9*DATA_W-1:0] win_data
`ifdef PIXEL_WINDOW_FRAME_DONE_EN
   ,
   output logic                frame_done
`endif
);

   localparam int unsigned COL_W = $clog2(IMG_WIDTH);
   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
   localparam int unsigned WIN_W = 9 * DATA_W;

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [WIN_W-1:0]  win_data_q, win_data_d;
   logic              win_valid_q, win_valid_d;

   logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
   logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];

   logic [COL_W-1:0]  pos_col;
   logic [ROW_W-1:0]  pos_row;
   logic [DATA_W-1:0] lb1_rd, lb2_rd;
   logic [DATA_W-1:0] new_pix [3];
   logic [WIN_W-1:0]  shifted;
   logic              last_col, last_row;

   // Position of the pixel presented this cycle; frame_start forces (0,0).
   always_comb begin
      pos_col  = frame_start ? '0 : col_q;
      pos_row  = frame_start ? '0 : row_q;
      last_col = (pos_col == COL_W'(IMG_WIDTH - 1));
      last_row = (pos_row == ROW_W'(IMG_HEIGHT - 1));
      lb1_rd   = lb1_mem[pos_col];
      lb2_rd   = lb2_mem[pos_col];
   end

   // Window shifted left by one column, new right column from line buffers.
   always_comb begin
      new_pix[0] = lb2_rd;
      new_pix[1] = lb1_rd;
      new_pix[2] = in_data;
      shifted    = '0;
      for (int r = 0; r < 3; r++) begin
         shifted[DATA_W*(3*r)   +: DATA_W] = win_q[DATA_W*(3*r+1) +: DATA_W];
         shifted[DATA_W*(3*r+1) +: DATA_W] = win_q[DATA_W*(3*r+2) +: DATA_W];
         shifted[DATA_W*(3*r+2) +: DATA_W] = new_pix[r];
      end
   end

   // Next-state: position counters, window shift, output qualification.
   always_comb begin
      col_d       = pos_col;
      row_d       = pos_row;
      win_d       = win_q;
      win_data_d  = win_data_q;
      win_valid_d = 1'b0;
      if (in_valid) begin
         win_d = shifted;
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : ROW_W'(pos_row + 1'b1);
         end else begin
            col_d = COL_W'(pos_col + 1'b1);
         end
         // Column gate keeps windows straddling a row boundary unflagged.
         win_valid_d = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
         if (win_valid_d) begin
            win_data_d = shifted;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '0;
         win_data_q  <= '0;
         win_valid_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         win_data_q  <= win_data_d;
         win_valid_q <= win_valid_d;
      end
   end

   // Line buffers: read-before-write at the same column, contents not reset.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb2_mem[pos_col] <= lb1_rd;
         lb1_mem[pos_col] <= in_data;
      end
   end

   assign win_valid = win_valid_q;
   assign win_data  = win_data_q;

`ifdef PIXEL_WINDOW_FRAME_DONE_EN
   logic frame_done_q, frame_done_d;

   // Pulse alongside the window of the frame's final pixel.
   always_comb begin
      frame_done_d = in_valid && last_col && last_row;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= frame_done_d;
      end
   end

   assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Directed bench for pixel_window_3x3 with a 4x4 image, pixel = base+4*row+col.
module tb_pixel_window_3x3;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        win_valid;
   logic [71:0] win_data;
`ifdef PIXEL_WINDOW_FRAME_DONE_EN
   logic        frame_done;
`endif

   int errors = 0;
   int checks = 0;

   pixel_window_3x3 #(
      .DATA_W(8),
      .IMG_WIDTH(4),
      .IMG_HEIGHT(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_start(frame_start),
      .in_valid(in_valid),
      .in_data(in_data),
      .win_valid(win_valid),
      .win_data(win_data)
`ifdef PIXEL_WINDOW_FRAME_DONE_EN
      ,
      .frame_done(frame_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected window for the pixel accepted at (r,c) of a frame with given base.
   function automatic logic [71:0] exp_win(input int base, input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[8*(3*i+j) +: 8] = 8'(base + 4*(r-2+i) + (c-2+j));
      return w;
   endfunction

   // Drive on negedge, return 1 time unit after the following posedge.
   task automatic step(input logic v, input logic [7:0] d, input logic fs);
      @(negedge clk);
      in_valid    = v;
      in_data     = d;
      frame_start = fs;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; frame_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", win_valid); end
      checks++;
      if (win_data !== 72'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", win_data); end
`ifdef PIXEL_WINDOW_FRAME_DONE_EN
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_continuous(input string tag);
      int pulses = 0;
      logic got_first = 1'b0;
      logic [71:0] first_w = '0, last_w = '0;
      for (int p = 0; p < 16; p++) begin
         int r = p / 4;
         int c = p % 4;
         logic ev;
         step(1'b1, 8'(p), 1'b0);
         ev = (r >= 2) && (c >= 2);
         checks++;
         if (win_valid !== ev) begin errors++; $display("FAIL %s_valid p=%0d got=%b exp=%b", tag, p, win_valid, ev); end
         if (ev) begin
            checks++;
            if (win_data !== exp_win(0, r, c)) begin errors++; $display("FAIL %s_data p=%0d got=%h exp=%h", tag, p, win_data, exp_win(0, r, c)); end
         end
`ifdef PIXEL_WINDOW_FRAME_DONE_EN
         checks++;
         if (frame_done !== (p == 15)) begin errors++; $display("FAIL %s_frame_done p=%0d got=%b exp=%b", tag, p, frame_done, (p == 15)); end
`endif
         if (win_valid === 1'b1) begin
            pulses++;
            if (!got_first) begin first_w = win_data; got_first = 1'b1; end
            last_w = win_data;
         end
      end
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if (win_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse_end got=%b exp=0", tag, win_valid); end
`ifdef PIXEL_WINDOW_FRAME_DONE_EN
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_frame_done_end got=%b exp=0", tag, frame_done); end
`endif
      checks++;
      if (pulses != 4) begin errors++; $display("FAIL %s_pulses got=%0d exp=4", tag, pulses); end
      checks++;
      if (first_w !== {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}) begin
         errors++; $display("FAIL %s_first_win got=%h", tag, first_w);
      end
      checks++;
      if (last_w !== {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5}) begin
         errors++; $display("FAIL %s_last_win got=%h", tag, last_w);
      end
   endtask

   task automatic test_gaps();
      int pulses = 0;
      for (int p = 0; p < 16; p++) begin
         int r = p / 4;
         int c = p % 4;
         logic ev;
         step(1'b1, 8'(p), 1'b0);
         ev = (r >= 2) && (c >= 2);
         checks++;
         if (win_valid !== ev) begin errors++; $display("FAIL gaps_valid p=%0d got=%b exp=%b", p, win_valid, ev); end
         if (ev) begin
            pulses++;
            checks++;
            if (win_data !== exp_win(0, r, c)) begin errors++; $display("FAIL gaps_data p=%0d got=%h exp=%h", p, win_data, exp_win(0, r, c)); end
         end
         step(1'b0, 8'bz, 1'b0);
         checks++;
         if (win_valid !== 1'b0) begin errors++; $display("FAIL gaps_idle p=%0d got=%b exp=0", p, win_valid); end
      end
      checks++;
      if (win_data !== exp_win(0, 3, 3)) begin errors++; $display("FAIL gaps_hold got=%h exp=%h", win_data, exp_win(0, 3, 3)); end
   endtask

   task automatic test_back_to_back();
      logic got = 1'b0;
      logic [71:0] f2_first = '0;
      for (int p = 0; p < 32; p++) begin
         int q = p % 16;
         int base = (p < 16) ? 0 : 8'h80;
         int r = q / 4;
         int c = q % 4;
         logic ev;
         step(1'b1, 8'(base + q), 1'b0);
         ev = (r >= 2) && (c >= 2);
         checks++;
         if (win_valid !== ev) begin errors++; $display("FAIL b2b_valid p=%0d got=%b exp=%b", p, win_valid, ev); end
         if (ev) begin
            checks++;
            if (win_data !== exp_win(base, r, c)) begin errors++; $display("FAIL b2b_data p=%0d got=%h exp=%h", p, win_data, exp_win(base, r, c)); end
         end
         if (p >= 16 && win_valid === 1'b1 && !got) begin f2_first = win_data; got = 1'b1; end
      end
      checks++;
      if (f2_first !== {8'h8A, 8'h89, 8'h88, 8'h86, 8'h85, 8'h84, 8'h82, 8'h81, 8'h80}) begin
         errors++; $display("FAIL b2b_f2_first got=%h", f2_first);
      end
      step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_frame_start();
      int first_valid = -1;
      for (int p = 0; p < 6; p++) begin
         step(1'b1, 8'(p), 1'b0);
         checks++;
         if (win_valid !== 1'b0) begin errors++; $display("FAIL fs_pre_valid p=%0d got=%b exp=0", p, win_valid); end
      end
      for (int p = 0; p < 16; p++) begin
         int r = p / 4;
         int c = p % 4;
         logic ev;
         step(1'b1, 8'(p), (p == 0));
         ev = (r >= 2) && (c >= 2);
         checks++;
         if (win_valid !== ev) begin errors++; $display("FAIL fs_valid p=%0d got=%b exp=%b", p, win_valid, ev); end
         if (ev) begin
            checks++;
            if (win_data !== exp_win(0, r, c)) begin errors++; $display("FAIL fs_data p=%0d got=%h exp=%h", p, win_data, exp_win(0, r, c)); end
         end
         if (win_valid === 1'b1 && first_valid < 0) first_valid = p + 1;
      end
      checks++;
      if (first_valid != 11) begin errors++; $display("FAIL fs_first_valid_accept got=%0d exp=11", first_valid); end
      step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int p = 0; p < 12; p++) step(1'b1, 8'(p), 1'b0);
      checks++;
      if (win_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", win_valid); end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (win_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", win_valid); end
      checks++;
      if (win_data !== 72'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", win_data); end
      @(negedge clk);
      rst_n = 1'b1;
      test_continuous("restart");
   endtask

   initial begin
      test_reset();
      test_continuous("cont");
      test_gaps();
      test_back_to_back();
      test_frame_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
